// File: rtl/rotate_right.sv
// Combinational fixed-distance right rotator.
// Instantiated once per barrel stage by sequential_rotate_right.
//
// Parameters:
//   WIDTH    - data width in bits
//   ROTATION - fixed right-rotation distance, 0 <= ROTATION < WIDTH
// Ports:
//   data    - vector to rotate
//   rotated - data rotated right by ROTATION positions
module rotate_right #(
    parameter int WIDTH    = 8,
    parameter int ROTATION = 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] rotated
);

    // Shift form rather than a part-select so a distance of zero stays legal.
    assign rotated = (data >> ROTATION) | (data << (WIDTH - ROTATION));

endmodule

// File: rtl/sequential_rotate_right.sv
// Multi-cycle variable-amount right rotator. One logarithmic barrel stage
// is applied per clock, so every operation is busy for STAGES cycles
// regardless of the amount, followed by a DONE cycle that holds the result
// until the consumer takes it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, in_ready high
// BUSY  | applying stage stage_cnt (rotate by 2^k if amount bit k set)
// DONE  | result presented on out_data/out_valid until out_ready
//
// Ports:
//   clock      - rising-edge clock
//   resetn     - asynchronous active-low reset
//   in_data    - vector to rotate
//   in_amount  - right-rotation amount, applied modulo WIDTH
//   in_valid   - request valid
//   in_ready   - request accepted on in_valid & in_ready
//   out_data   - rotated result (zero outside DONE)
//   out_valid  - result valid
//   out_ready  - result consumed on out_valid & out_ready
//   busy       - operation in flight (BUSY or DONE)
module sequential_rotate_right #(
    parameter int  WIDTH        = 8,
    localparam int AMOUNT_WIDTH = $clog2(WIDTH),
    localparam int STAGES       = AMOUNT_WIDTH
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [AMOUNT_WIDTH-1:0] in_amount,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int CNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [WIDTH-1:0]        data_q;
    logic [AMOUNT_WIDTH-1:0] amount_q;
    logic [CNT_W-1:0]        stage_cnt;
    logic [WIDTH-1:0]        stage_out [STAGES];
    logic [WIDTH-1:0]        data_next;
    logic                    last_stage;
    logic                    accept;

    // Stage k rotates by 2^k; summing the selected stages gives rotation by
    // the amount, which wraps modulo WIDTH naturally for any WIDTH.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rotate_right #(
            .WIDTH    (WIDTH),
            .ROTATION (1 << k)
        ) u_rotate (
            .data    (data_q),
            .rotated (stage_out[k])
        );
    end

    assign data_next  = amount_q[stage_cnt] ? stage_out[stage_cnt] : data_q;
    assign last_stage = (stage_cnt == CNT_W'(STAGES - 1));
    assign accept     = in_valid & in_ready;

    assign out_valid = (state == DONE);
    assign out_data  = (state == DONE) ? data_q : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // in_ready is gated by resetn so it reads low while reset is held even
    // though the state register already sits in IDLE.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = resetn;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_stage) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    in_ready   = resetn;
                    state_next = in_valid ? BUSY : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_q    <= '0;
            amount_q  <= '0;
            stage_cnt <= '0;
        end else if (accept) begin
            data_q    <= in_data;
            amount_q  <= in_amount;
            stage_cnt <= '0;
        end else if (state == BUSY) begin
            data_q    <= data_next;
            stage_cnt <= stage_cnt + 1'b1;
        end
    end

endmodule
